// File: rtl/multiplier_booth_seq_if.sv
// rtl/multiplier_booth_seq_if.sv - operand/product handshake bundle for the sequential Booth multiplier
interface multiplier_booth_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/multiplier_booth_seq.sv
// rtl/multiplier_booth_seq.sv - radix-4 Booth multiplier, one digit per cycle through a single adder
module multiplier_booth_seq #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multiplier_booth_seq_if.slave  bus
);
    localparam int NSTEP = WIDTH / 2 + 1;
    localparam int XW    = WIDTH + 2;
    localparam int CW    = $clog2(NSTEP + 1);
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [XW-1:0]      mcand;
    logic [2*XW-1:0]    acc;
    logic               prev;
    logic [2*WIDTH-1:0] product_q;

    logic [2:0]         trip;
    logic [XW+1:0]      a_ext;
    logic [XW+1:0]      sel;
    logic [XW+1:0]      sum;
    logic [2*XW+1:0]    wide;
    logic [2*XW-1:0]    acc_next;
    logic [XW-1:0]      a_cap;
    logic [XW-1:0]      b_cap;

    // Two guard bits on the adder so +-2A never overflows before the shift.
    always_comb begin
        trip  = {acc[1:0], prev};
        a_ext = {{2{mcand[XW-1]}}, mcand};
        sel   = '0;
        case (trip)
            3'b001, 3'b010: sel = a_ext;
            3'b011:         sel = a_ext << 1;
            3'b100:         sel = -(a_ext << 1);
            3'b101, 3'b110: sel = -a_ext;
            default:        sel = '0;
        endcase
        sum      = {{2{acc[2*XW-1]}}, acc[2*XW-1:XW]} + sel;
        wide     = {sum, acc[XW-1:0]};
        acc_next = wide[2*XW+1:2];
    end

    always_comb begin
        a_cap = bus.signed_mode ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
        b_cap = bus.signed_mode ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            acc       <= '0;
            prev      <= 1'b0;
            product_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        mcand <= a_cap;
                        acc   <= {{XW{1'b0}}, b_cap};
                        prev  <= 1'b0;
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc  <= acc_next;
                    prev <= acc[1];
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        product_q <= acc_next[2*WIDTH-1:0];
                        cnt       <= '0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.product   = product_q;
endmodule

// File: tb/tb_multiplier_booth_seq.sv
// tb/tb_multiplier_booth_seq.sv - self-checking bench for 8- and 16-bit Booth multiplier instances
module tb_multiplier_booth_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiplier_booth_seq_if #(.WIDTH(8))  bus8 ();
    multiplier_booth_seq_if #(.WIDTH(16)) bus16 ();

    multiplier_booth_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    multiplier_booth_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    typedef struct {
        int          w;
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];
    int checks = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(int w, logic [15:0] a, logic [15:0] b, logic sm);
        longint x, y, p;
        if (w == 8) begin
            x = sm ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            y = sm ? longint'($signed(b[7:0])) : longint'(b[7:0]);
        end else begin
            x = sm ? longint'($signed(a)) : longint'(a);
            y = sm ? longint'($signed(b)) : longint'(b);
        end
        p = x * y;
        return (w == 8) ? {16'h0, p[15:0]} : p[31:0];
    endfunction

    function automatic logic ir(int w);
        return (w == 8) ? bus8.in_ready : bus16.in_ready;
    endfunction
    function automatic logic ov(int w);
        return (w == 8) ? bus8.out_valid : bus16.out_valid;
    endfunction
    function automatic logic bz(int w);
        return (w == 8) ? bus8.busy : bus16.busy;
    endfunction
    function automatic logic [31:0] prod(int w);
        return (w == 8) ? {16'h0, bus8.product} : bus16.product;
    endfunction

    task automatic drive(int w, logic [15:0] a, logic [15:0] b, logic sm, logic v);
        if (w == 8) begin
            bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.signed_mode = sm; bus8.in_valid = v;
        end else begin
            bus16.a = a; bus16.b = b; bus16.signed_mode = sm; bus16.in_valid = v;
        end
    endtask

    task automatic set_ordy(int w, logic v);
        if (w == 8) bus8.out_ready = v;
        else        bus16.out_ready = v;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic accept(int w, logic [15:0] a, logic [15:0] b, logic sm, string name);
        int n = 0;
        while (!ir(w) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({name, " in_ready"}, 32'(ir(w)), 32'd1);
        drive(w, a, b, sm, 1'b1);
        @(posedge clk); #1;
        drive(w, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    endtask

    // Operands are scrambled every CALC cycle; the result must not care.
    task automatic wait_done(int w, output int lat);
        lat = 0;
        do begin
            drive(w, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            @(posedge clk); #1; lat++;
        end while (!ov(w) && lat < 50);
    endtask

    task automatic run_op(int w, logic [15:0] a, logic [15:0] b, logic sm,
                          logic [31:0] exp, int hold, string name);
        int lat;
        set_ordy(w, hold < 0);
        accept(w, a, b, sm, name);
        wait_done(w, lat);
        check({name, " latency"}, 32'(lat), 32'(w / 2 + 1));
        check({name, " product"}, prod(w), exp);
        if (hold > 0) repeat (hold) begin @(posedge clk); #1; end
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        set_ordy(w, 1'b0);
        check({name, " ov_fall"}, 32'(ov(w)), 32'd0);
        check({name, " ir_rise"}, 32'(ir(w)), 32'd1);
        check({name, " held"}, prod(w), exp);
    endtask

    initial begin
        int lat;
        logic saw;
        logic [15:0] ra, rb;
        logic rs;

        vecs[0] = '{8,  16'd5,    16'd7,    1'b0, 32'd35};
        vecs[1] = '{8,  16'hFF,   16'hFF,   1'b0, 32'h0000FE01};
        vecs[2] = '{8,  16'hFF,   16'h01,   1'b0, 32'h000000FF};
        vecs[3] = '{8,  16'h00,   16'h00,   1'b0, 32'h00000000};
        vecs[4] = '{8,  16'hFF,   16'hFF,   1'b1, 32'h00000001};
        vecs[5] = '{8,  16'h80,   16'h7F,   1'b1, 32'h0000C080};
        vecs[6] = '{8,  16'h80,   16'h80,   1'b1, 32'h00004000};
        vecs[7] = '{8,  16'h37,   16'hEA,   1'b1, 32'h0000FB46};
        vecs[8] = '{16, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
        vecs[9] = '{16, 16'h8000, 16'h8000, 1'b1, 32'h40000000};

        drive(8, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(16, 16'h0, 16'h0, 1'b0, 1'b0);
        set_ordy(8, 1'b0);
        set_ordy(16, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 8; w <= 16; w += 8) begin
            check("reset in_ready", 32'(ir(w)), 32'd1);
            check("reset out_valid", 32'(ov(w)), 32'd0);
            check("reset busy", 32'(bz(w)), 32'd0);
            check("reset product", prod(w), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, 0,
                   $sformatf("vec%0d", i));

        // Backpressure: result held, new request ignored, then next op is correct.
        accept(8, 16'd12, 16'd13, 1'b0, "bp");
        wait_done(8, lat);
        check("bp latency", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            drive(8, 16'd3, 16'd3, 1'b0, 1'b1);
            @(posedge clk); #1;
            check("bp out_valid", 32'(ov(8)), 32'd1);
            check("bp product", prod(8), 32'd156);
            check("bp in_ready", 32'(ir(8)), 32'd0);
        end
        drive(8, 16'd3, 16'd3, 1'b0, 1'b0);
        set_ordy(8, 1'b1);
        @(posedge clk); #1;
        set_ordy(8, 1'b0);
        check("bp release ov", 32'(ov(8)), 32'd0);
        check("bp release ir", 32'(ir(8)), 32'd1);
        run_op(8, 16'd3, 16'hFD, 1'b1, 32'h0000FFF7, 0, "bp_next");

        // out_ready held high: DONE lasts one cycle.
        run_op(16, 16'h1234, 16'h5678, 1'b0, ref_mul(16, 16'h1234, 16'h5678, 1'b0), -1, "ordy_high");

        // Reset during the third CALC cycle.
        accept(8, 16'h55, 16'h77, 1'b0, "rst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst busy_before", 32'(bz(8)), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst out_valid", 32'(ov(8)), 32'd0);
        check("rst product", prod(8), 32'd0);
        check("rst in_ready", 32'(ir(8)), 32'd1);
        check("rst busy", 32'(bz(8)), 32'd0);
        saw = 1'b0;
        repeat (10) begin @(posedge clk); #1; saw |= ov(8); end
        check("rst no_stale_ov", 32'(saw), 32'd0);

        // Reset beats a simultaneous request.
        rst_n = 1'b0;
        drive(8, 16'd9, 16'd9, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(8, 16'd9, 16'd9, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_vs_valid busy", 32'(bz(8)), 32'd0);
        check("rst_vs_valid ir", 32'(ir(8)), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'(i & 1);
            run_op(16, ra, rb, rs, ref_mul(16, ra, rb, rs), int'($urandom_range(0, 3)) - 1, "rand16");
        end
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom & 32'hFF); rb = 16'($urandom & 32'hFF); rs = 1'(i & 1);
            run_op(8, ra, rb, rs, ref_mul(8, ra, rb, rs), int'($urandom_range(0, 3)) - 1, "rand8");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
